// File: rtl/mux_4to1_pkg.sv
// Shared types and helpers for the registered 4-to-1 lane selector.
// Holds the lane count, the select type and the one-hot encoding function.
package mux_4to1_pkg;

   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [NUM_IN-1:0] onehot_t;

   // Every select code maps to exactly one set bit, so no default lane exists.
   function automatic onehot_t onehot4(input sel_t sel);
      onehot_t oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_4to1_dec.sv
// 2-to-4 one-hot decoder feeding the AND-OR lane reduction in mux_4to1.
module mux_4to1_dec
   import mux_4to1_pkg::*;
(
   input  sel_t    i_sel,
   output onehot_t o_oh
);

   assign o_oh = onehot4(i_sel);

endmodule

// File: rtl/mux_4to1.sv
// Clocked 4-to-1 lane selector: one-hot decode of s, AND-OR reduction over the
// four packed lanes of i, optional output register qualified by in_valid.
module mux_4to1
   import mux_4to1_pkg::*;
#(
   parameter int DATA_W  = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN*DATA_W-1:0] i,
   input  logic [SEL_W-1:0]         s,
   input  logic                     in_valid,
   output logic [DATA_W-1:0]        out,
   output logic                     out_valid
);

   onehot_t           w_oh;
   logic [DATA_W-1:0] w_sel_lane;

   mux_4to1_dec u_dec (
      .i_sel (sel_t'(s)),
      .o_oh  (w_oh)
   );

   // Masking with the one-hot keeps unselected (possibly unknown) lanes out of the result.
   always_comb begin
      // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
      w_sel_lane = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w_sel_lane = w_sel_lane | (i[k*DATA_W +: DATA_W] & {DATA_W{w_oh[k]}});
      end
   end

   if (REG_OUT) begin : g_reg
      logic [DATA_W-1:0] r_out;
      logic              r_out_valid;

      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
               r_out <= w_sel_lane;
            end
         end
      end

      assign out       = r_out;
      assign out_valid = r_out_valid;
   end else begin : g_comb
      // Clock and reset have no role in the pass-through configuration.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign out       = w_sel_lane;
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: registered 1-bit and 8-bit instances plus a
// combinational instance, compared against a shift-and-mask lane model.
module tb_mux_4to1;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [3:0]  i1;
   logic [1:0]  s1;
   logic        v1;
   logic        out1, ov1;

   logic [31:0] i8;
   logic [1:0]  s8;
   logic        v8;
   logic [7:0]  out8;
   logic        ov8;

   logic [3:0]  ic;
   logic [1:0]  sc;
   logic        vc;
   logic        outc, ovc;

   logic        exp1_out, exp1_val;
   logic [7:0]  exp8_out;
   logic        exp8_val;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mux_4to1 #(.DATA_W(1), .REG_OUT(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i(i1), .s(s1), .in_valid(v1),
      .out(out1), .out_valid(ov1)
   );

   mux_4to1 #(.DATA_W(8), .REG_OUT(1'b1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .i(i8), .s(s8), .in_valid(v8),
      .out(out8), .out_valid(ov8)
   );

   mux_4to1 #(.DATA_W(1), .REG_OUT(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .i(ic), .s(sc), .in_valid(vc),
      .out(outc), .out_valid(ovc)
   );

   // Reference: lane k is the value found k*W bits up from the bottom of the bus.
   function automatic logic lane1(input logic [3:0] iv, input logic [1:0] sv);
      logic [3:0] t;
      t = iv >> sv;
      return t[0];
   endfunction

   function automatic logic [7:0] lane8(input logic [31:0] iv, input logic [1:0] sv);
      logic [31:0] t;
      t = iv >> (8 * int'(sv));
      return t[7:0];
   endfunction

   // One rising edge; the model samples the same inputs the DUTs see, then outputs are read 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         exp1_out = 1'b0; exp1_val = 1'b0;
         exp8_out = 8'h00; exp8_val = 1'b0;
      end else begin
         exp1_val = v1;
         if (v1) exp1_out = lane1(i1, s1);
         exp8_val = v8;
         if (v8) exp8_out = lane8(i8, s8);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i1 = 4'b1111; s1 = 2'd0; v1 = 1'b1;
      i8 = 32'hFFFF_FFFF; s8 = 2'd1; v8 = 1'b1;
      tick();
      tick();
      n_total++;
      if (out1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL reset_w1 out=%b valid=%b expected 0/0", out1, ov1);
      else n_pass++;
      n_total++;
      if (out8 !== 8'h00 || ov8 !== 1'b0) $display("FAIL reset_w8 out=%h valid=%b expected 00/0", out8, ov8);
      else n_pass++;
      rst_n = 1'b1;
      v1 = 1'b0; v8 = 1'b0;
      tick();
   endtask

   task automatic test_pattern();
      logic [3:0] want;
      want = 4'b1010;
      i1 = 4'b1010; v1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s1 = 2'(k);
         tick();
         n_total++;
         if (out1 !== want[k] || ov1 !== 1'b1)
            $display("FAIL pattern s=%0d out=%b valid=%b expected %b/1", k, out1, ov1, want[k]);
         else n_pass++;
      end
   endtask

   task automatic test_sweep();
      v1 = 1'b1;
      for (int iv = 0; iv < 16; iv++) begin
         for (int sv = 0; sv < 4; sv++) begin
            i1 = 4'(iv); s1 = 2'(sv);
            tick();
            n_total++;
            if (out1 !== exp1_out || ov1 !== 1'b1)
               $display("FAIL sweep i=%b s=%0d out=%b valid=%b expected %b/1", i1, sv, out1, ov1, exp1_out);
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      i1 = 4'b1111; s1 = 2'd2; v1 = 1'b1;
      i8 = {8'h44, 8'h33, 8'h22, 8'h11}; s8 = 2'd3; v8 = 1'b1;
      tick();
      n_total++;
      if (out1 !== 1'b1) $display("FAIL async_pre out=%b expected 1", out1);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      exp1_out = 1'b0; exp1_val = 1'b0; exp8_out = 8'h00; exp8_val = 1'b0;
      #1;
      n_total++;
      if (out1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL async_w1 out=%b valid=%b expected 0/0", out1, ov1);
      else n_pass++;
      n_total++;
      if (out8 !== 8'h00 || ov8 !== 1'b0) $display("FAIL async_w8 out=%h valid=%b expected 00/0", out8, ov8);
      else n_pass++;
      tick();
      n_total++;
      if (out1 !== 1'b0 || ov1 !== 1'b0) $display("FAIL async_hold out=%b valid=%b expected 0/0", out1, ov1);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      n_total++;
      if (out1 !== 1'b1 || ov1 !== 1'b1) $display("FAIL async_release out=%b valid=%b expected 1/1", out1, ov1);
      else n_pass++;
   endtask

   task automatic test_hold();
      i1 = 4'b0000; s1 = 2'd3; v1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_total++;
         if (out1 !== 1'b1 || ov1 !== 1'b0)
            $display("FAIL hold cycle=%0d out=%b valid=%b expected 1/0", k, out1, ov1);
         else n_pass++;
      end
   endtask

   task automatic test_wide();
      logic [7:0] want [4];
      want = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      i8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; v8 = 1'b1; v1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s8 = 2'(3 - k);
         tick();
         n_total++;
         if (out8 !== want[3-k] || ov8 !== 1'b1)
            $display("FAIL wide s=%0d out=%h valid=%b expected %h/1", 3 - k, out8, ov8, want[3-k]);
         else n_pass++;
      end
   endtask

   task automatic test_comb();
      ic = 4'b0100; sc = 2'd2; vc = 1'b1;
      #1;
      n_total++;
      if (outc !== 1'b1 || ovc !== 1'b1) $display("FAIL comb_basic out=%b valid=%b expected 1/1", outc, ovc);
      else n_pass++;
      vc = 1'b0;
      #1;
      n_total++;
      if (ovc !== 1'b0) $display("FAIL comb_valid valid=%b expected 0", ovc);
      else n_pass++;
      ic = 4'bx1xx;
      #1;
      n_total++;
      if (outc !== 1'b1) $display("FAIL comb_xmask1 out=%b expected 1", outc);
      else n_pass++;
      ic = 4'bx0xx;
      #1;
      n_total++;
      if (outc !== 1'b0) $display("FAIL comb_xmask0 out=%b expected 0", outc);
      else n_pass++;
      for (int k = 0; k < 32; k++) begin
         ic = 4'($urandom); sc = 2'($urandom); vc = 1'($urandom);
         #1;
         n_total++;
         if (outc !== lane1(ic, sc) || ovc !== vc)
            $display("FAIL comb_rand i=%b s=%0d out=%b valid=%b expected %b/%b", ic, sc, outc, ovc, lane1(ic, sc), vc);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 200; k++) begin
         i1 = 4'($urandom); s1 = 2'($urandom); v1 = 1'($urandom);
         i8 = $urandom;     s8 = 2'($urandom); v8 = 1'($urandom);
         tick();
         n_total++;
         if (out1 !== exp1_out || ov1 !== exp1_val)
            $display("FAIL rand_w1 n=%0d out=%b valid=%b expected %b/%b", k, out1, ov1, exp1_out, exp1_val);
         else n_pass++;
         n_total++;
         if (out8 !== exp8_out || ov8 !== exp8_val)
            $display("FAIL rand_w8 n=%0d out=%h valid=%b expected %h/%b", k, out8, ov8, exp8_out, exp8_val);
         else n_pass++;
      end
   endtask

   initial begin
      ic = 4'b0000; sc = 2'd0; vc = 1'b0;
      test_reset();
      test_pattern();
      test_sweep();
      test_async_reset();
      test_hold();
      test_wide();
      test_comb();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
